// File: rtl/rob_queue_pkg.sv
// Shared widths and entry layout for the reorder buffer.
// Imported by rob_queue and rob_query_port.
package rob_queue_pkg;

  localparam int ROB_DEPTH_DEF      = 16;
  localparam int ROB_ID_WIDTH_DEF   = 4;
  localparam int EXC_TYPE_BUS_WIDTH = 8;
  localparam int REG_ADDR_W         = 5;
  localparam int DATA_W             = 32;
  localparam int ADDR_W             = 32;

  typedef logic [EXC_TYPE_BUS_WIDTH-1:0] exc_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_write_en;
    logic [REG_ADDR_W-1:0] reg_write_addr;
    logic [ADDR_W-1:0]     pc;
    exc_t                  exception_type;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/rob_query_port.sv
// Operand-reference lookup into the ROB: ready/data for one id.
// ROB_WB_BYPASS_EN forwards a same-cycle writeback to the query.
module rob_query_port
  import rob_queue_pkg::*;
#(
  parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF
) (
  input  logic [ROB_ID_WIDTH-1:0]           query_id,
  input  logic [ROB_DEPTH-1:0]              valid,
  input  logic [ROB_DEPTH-1:0]              done,
  input  logic [ROB_DEPTH-1:0][DATA_W-1:0]  data,
  input  logic                              wb_en,
  input  logic [ROB_ID_WIDTH-1:0]           wb_id,
  input  logic [DATA_W-1:0]                 wb_data,
  output logic                              query_ready,
  output logic [DATA_W-1:0]                 query_data
);

  always_comb begin
    query_ready = valid[query_id] && done[query_id];
    query_data  = valid[query_id] ? data[query_id] : '0;
`ifdef ROB_WB_BYPASS_EN
    if (wb_en && (wb_id == query_id) && valid[query_id]) begin
      query_ready = 1'b1;
      query_data  = wb_data;
    end
`endif
  end

`ifndef ROB_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_id, wb_data};
`endif

endmodule

// File: rtl/rob_queue.sv
// In-order reorder buffer: allocate, writeback, query, commit.
// Ports: alloc_*, wb_*, query_*, commit_*; ROB_WB_BYPASS_EN optional.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_en,
  input  logic                          alloc_done,
  input  logic                          alloc_reg_write_en,
  input  logic [REG_ADDR_W-1:0]         alloc_reg_write_addr,
  input  logic [EXC_TYPE_BUS_WIDTH-1:0] alloc_exception_type,
  input  logic [ADDR_W-1:0]             alloc_pc,
  output logic [ROB_ID_WIDTH-1:0]       alloc_id,
  output logic                          full,
  input  logic                          wb_en,
  input  logic [ROB_ID_WIDTH-1:0]       wb_id,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [EXC_TYPE_BUS_WIDTH-1:0] wb_exception_type,
  input  logic [ROB_ID_WIDTH-1:0]       query_id_1,
  input  logic [ROB_ID_WIDTH-1:0]       query_id_2,
  output logic                          query_ready_1,
  output logic                          query_ready_2,
  output logic [DATA_W-1:0]             query_data_1,
  output logic [DATA_W-1:0]             query_data_2,
  output logic                          commit_en,
  output logic                          commit_reg_write_en,
  output logic [REG_ADDR_W-1:0]         commit_reg_write_addr,
  output logic [DATA_W-1:0]             commit_data,
  output logic [ADDR_W-1:0]             commit_pc,
  output logic                          commit_exc,
  output logic [EXC_TYPE_BUS_WIDTH-1:0] commit_exception_type
);

  localparam int PW = ROB_ID_WIDTH + 1;

  rob_entry_t ent [ROB_DEPTH];

  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [ROB_ID_WIDTH-1:0] head_idx;
  logic [ROB_ID_WIDTH-1:0] tail_idx;
  rob_entry_t              head_ent;
  logic                    do_alloc;
  logic                    do_commit;

  assign head_idx  = head[ROB_ID_WIDTH-1:0];
  assign tail_idx  = tail[ROB_ID_WIDTH-1:0];
  assign head_ent  = ent[head_idx];
  // Same index, opposite lap: every slot is occupied.
  assign full      = (head_idx == tail_idx) &&
                     (head[ROB_ID_WIDTH] != tail[ROB_ID_WIDTH]);
  assign alloc_id  = tail_idx;
  assign do_alloc  = alloc_en && !full;
  assign do_commit = head_ent.valid && head_ent.done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
      head                  <= '0;
      tail                  <= '0;
      commit_en             <= 1'b0;
      commit_reg_write_en   <= 1'b0;
      commit_reg_write_addr <= '0;
      commit_data           <= '0;
      commit_pc             <= '0;
      commit_exc            <= 1'b0;
      commit_exception_type <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent[i].valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
      commit_en <= 1'b0;
    end else begin
      if (wb_en && ent[wb_id].valid) begin
        ent[wb_id].done <= 1'b1;
        ent[wb_id].data <= wb_data;
        ent[wb_id].exception_type <=
          ent[wb_id].exception_type | wb_exception_type;
      end
      if (do_commit) begin
        ent[head_idx].valid   <= 1'b0;
        head                  <= head + PW'(1);
        commit_en             <= 1'b1;
        commit_exc            <= |head_ent.exception_type;
        // A faulting instruction must not update architectural state.
        commit_reg_write_en   <= head_ent.reg_write_en &&
                                 !(|head_ent.exception_type);
        commit_reg_write_addr <= head_ent.reg_write_addr;
        commit_data           <= head_ent.data;
        commit_pc             <= head_ent.pc;
        commit_exception_type <= head_ent.exception_type;
      end else begin
        commit_en <= 1'b0;
      end
      if (do_alloc) begin
        ent[tail_idx] <= '{
          valid:          1'b1,
          done:           alloc_done || (alloc_exception_type != '0),
          reg_write_en:   alloc_reg_write_en,
          reg_write_addr: alloc_reg_write_addr,
          pc:             alloc_pc,
          exception_type: alloc_exception_type,
          data:           '0
        };
        tail <= tail + PW'(1);
      end
    end
  end

  logic [ROB_DEPTH-1:0]             q_valid;
  logic [ROB_DEPTH-1:0]             q_done;
  logic [ROB_DEPTH-1:0][DATA_W-1:0] q_data;

  always_comb begin
    q_valid = '0;
    q_done  = '0;
    q_data  = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      q_valid[i] = ent[i].valid;
      q_done[i]  = ent[i].done;
      q_data[i]  = ent[i].data;
    end
  end

  rob_query_port #(
    .ROB_DEPTH    (ROB_DEPTH),
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_query_1 (
    .query_id    (query_id_1),
    .valid       (q_valid),
    .done        (q_done),
    .data        (q_data),
    .wb_en       (wb_en),
    .wb_id       (wb_id),
    .wb_data     (wb_data),
    .query_ready (query_ready_1),
    .query_data  (query_data_1)
  );

  rob_query_port #(
    .ROB_DEPTH    (ROB_DEPTH),
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_query_2 (
    .query_id    (query_id_2),
    .valid       (q_valid),
    .done        (q_done),
    .data        (q_data),
    .wb_en       (wb_en),
    .wb_id       (wb_id),
    .wb_data     (wb_data),
    .query_ready (query_ready_2),
    .query_data  (query_data_2)
  );

endmodule

// File: tb/tb_rob_queue.sv
// Self-checking bench for rob_queue: directed scenarios
// plus randomized traffic against a count-based queue model.
module tb_rob_queue;
  import rob_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_en;
  logic        alloc_done;
  logic        alloc_reg_write_en;
  logic [4:0]  alloc_reg_write_addr;
  logic [7:0]  alloc_exception_type;
  logic [31:0] alloc_pc;
  logic [3:0]  alloc_id;
  logic        full;
  logic        wb_en;
  logic [3:0]  wb_id;
  logic [31:0] wb_data;
  logic [7:0]  wb_exception_type;
  logic [3:0]  query_id_1;
  logic [3:0]  query_id_2;
  logic        query_ready_1;
  logic        query_ready_2;
  logic [31:0] query_data_1;
  logic [31:0] query_data_2;
  logic        commit_en;
  logic        commit_reg_write_en;
  logic [4:0]  commit_reg_write_addr;
  logic [31:0] commit_data;
  logic [31:0] commit_pc;
  logic        commit_exc;
  logic [7:0]  commit_exception_type;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_queue dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .alloc_en              (alloc_en),
    .alloc_done            (alloc_done),
    .alloc_reg_write_en    (alloc_reg_write_en),
    .alloc_reg_write_addr  (alloc_reg_write_addr),
    .alloc_exception_type  (alloc_exception_type),
    .alloc_pc              (alloc_pc),
    .alloc_id              (alloc_id),
    .full                  (full),
    .wb_en                 (wb_en),
    .wb_id                 (wb_id),
    .wb_data               (wb_data),
    .wb_exception_type     (wb_exception_type),
    .query_id_1            (query_id_1),
    .query_id_2            (query_id_2),
    .query_ready_1         (query_ready_1),
    .query_ready_2         (query_ready_2),
    .query_data_1          (query_data_1),
    .query_data_2          (query_data_2),
    .commit_en             (commit_en),
    .commit_reg_write_en   (commit_reg_write_en),
    .commit_reg_write_addr (commit_reg_write_addr),
    .commit_data           (commit_data),
    .commit_pc             (commit_pc),
    .commit_exc            (commit_exc),
    .commit_exception_type (commit_exception_type)
  );

  task automatic idle();
    flush                = 1'b0;
    alloc_en             = 1'b0;
    alloc_done           = 1'b0;
    alloc_reg_write_en   = 1'b0;
    alloc_reg_write_addr = '0;
    alloc_exception_type = '0;
    alloc_pc             = '0;
    wb_en                = 1'b0;
    wb_id                = '0;
    wb_data              = '0;
    wb_exception_type    = '0;
    query_id_1           = '0;
    query_id_2           = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (full !== 1'b0 || alloc_id !== 4'd0 || commit_en !== 1'b0) begin
      failures++;
      $display("FAIL reset: full=%b id=%0d cen=%b want 0/0/0",
               full, alloc_id, commit_en);
    end
    checks++;
    if (commit_pc !== 32'd0 || commit_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs: pc=%h data=%h want 0/0",
               commit_pc, commit_data);
    end
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alloc_commit();
    logic [31:0] pcs [3];
    pcs = '{32'h100, 32'h104, 32'h108};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_en             = 1'b1;
      alloc_pc             = pcs[i];
      alloc_reg_write_en   = 1'b1;
      alloc_reg_write_addr = 5'(i + 5);
      #1;
      checks++;
      if (alloc_id !== 4'(i) || full !== 1'b0) begin
        failures++;
        $display("FAIL alloc_id%0d: id=%0d full=%b want %0d/0",
                 i, alloc_id, full, i);
      end
      tick();
      checks++;
      if (commit_en !== 1'b0) begin
        failures++;
        $display("FAIL alloc_no_commit%0d: cen=%b want 0", i, commit_en);
      end
    end
    idle();
    wb_en = 1'b1; wb_id = 4'd1; wb_data = 32'hAA;
    tick();
    checks++;
    if (commit_en !== 1'b0) begin
      failures++;
      $display("FAIL ooo_wb_commit: cen=%b want 0", commit_en);
    end
    wb_id = 4'd0; wb_data = 32'h55;
    tick();
    idle();
    query_id_1 = 4'd0;
    query_id_2 = 4'd2;
    #1;
    checks++;
    if (query_ready_1 !== 1'b1 || query_data_1 !== 32'h55 ||
        query_ready_2 !== 1'b0 || query_data_2 !== 32'h0) begin
      failures++;
      $display("FAIL query: r1=%b d1=%h r2=%b d2=%h want 1/55/0/0",
               query_ready_1, query_data_1, query_ready_2, query_data_2);
    end
    tick();
    checks++;
    if (commit_en !== 1'b1 || commit_pc !== 32'h100 ||
        commit_data !== 32'h55 || commit_reg_write_en !== 1'b1 ||
        commit_reg_write_addr !== 5'd5) begin
      failures++;
      $display("FAIL commit0: en=%b pc=%h d=%h we=%b a=%0d want 1/100/55/1/5",
               commit_en, commit_pc, commit_data,
               commit_reg_write_en, commit_reg_write_addr);
    end
    tick();
    checks++;
    if (commit_en !== 1'b1 || commit_pc !== 32'h104 ||
        commit_data !== 32'hAA) begin
      failures++;
      $display("FAIL commit1: en=%b pc=%h d=%h want 1/104/aa",
               commit_en, commit_pc, commit_data);
    end
    tick();
    checks++;
    if (commit_en !== 1'b0 || commit_pc !== 32'h104) begin
      failures++;
      $display("FAIL commit_hold: en=%b pc=%h want 0/104",
               commit_en, commit_pc);
    end
  endtask

  task automatic test_full_wrap();
    int ncommit;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_en = 1'b1;
      alloc_pc = 32'h1000 + 32'(i * 4);
      #1;
      checks++;
      if (alloc_id !== 4'(i) || full !== 1'b0) begin
        failures++;
        $display("FAIL fill%0d: id=%0d full=%b want %0d/0",
                 i, alloc_id, full, i);
      end
      tick();
    end
    checks++;
    if (full !== 1'b1 || alloc_id !== 4'd0) begin
      failures++;
      $display("FAIL full: full=%b id=%0d want 1/0", full, alloc_id);
    end
    alloc_pc = 32'hDEAD;
    tick();
    checks++;
    if (full !== 1'b1 || alloc_id !== 4'd0 || commit_en !== 1'b0) begin
      failures++;
      $display("FAIL refused: full=%b id=%0d cen=%b want 1/0/0",
               full, alloc_id, commit_en);
    end
    idle();
    ncommit = 0;
    for (int i = 0; i < 18; i++) begin
      wb_en   = (i < 15);
      wb_id   = 4'(i);
      wb_data = 32'(i);
      tick();
      if (commit_en) ncommit++;
    end
    idle();
    checks++;
    if (ncommit != 15 || full !== 1'b0 || alloc_id !== 4'd0) begin
      failures++;
      $display("FAIL drain: commits=%0d full=%b id=%0d want 15/0/0",
               ncommit, full, alloc_id);
    end
    for (int i = 0; i < 15; i++) begin
      alloc_en = 1'b1;
      #1;
      checks++;
      if (alloc_id !== 4'(i) || full !== 1'b0) begin
        failures++;
        $display("FAIL wrap%0d: id=%0d full=%b want %0d/0",
                 i, alloc_id, full, i);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (full !== 1'b1 || alloc_id !== 4'd15) begin
      failures++;
      $display("FAIL wrap_full: full=%b id=%0d want 1/15", full, alloc_id);
    end
  endtask

  task automatic test_exception();
    do_reset();
    alloc_en             = 1'b1;
    alloc_reg_write_en   = 1'b1;
    alloc_reg_write_addr = 5'd3;
    alloc_exception_type = 8'h01;
    alloc_pc             = 32'h200;
    tick();
    idle();
    checks++;
    if (commit_en !== 1'b0) begin
      failures++;
      $display("FAIL exc_early: cen=%b want 0", commit_en);
    end
    tick();
    checks++;
    if (commit_en !== 1'b1 || commit_exc !== 1'b1 ||
        commit_reg_write_en !== 1'b0 || commit_exception_type !== 8'h01 ||
        commit_pc !== 32'h200) begin
      failures++;
      $display("FAIL exc: en=%b exc=%b we=%b t=%h pc=%h want 1/1/0/01/200",
               commit_en, commit_exc, commit_reg_write_en,
               commit_exception_type, commit_pc);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_en = 1'b1;
      alloc_pc = 32'h300 + 32'(i * 4);
      tick();
    end
    idle();
    wb_en = 1'b1; wb_id = 4'd0; wb_data = 32'h77;
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (commit_en !== 1'b0 || alloc_id !== 4'd0 || full !== 1'b0) begin
      failures++;
      $display("FAIL flush: cen=%b id=%0d full=%b want 0/0/0",
               commit_en, alloc_id, full);
    end
    for (int i = 0; i < 3; i++) begin
      query_id_1 = 4'(i);
      query_id_2 = 4'(i);
      #1;
      checks++;
      if (query_ready_1 !== 1'b0 || query_ready_2 !== 1'b0 ||
          query_data_1 !== 32'h0) begin
        failures++;
        $display("FAIL flush_q%0d: r1=%b r2=%b d1=%h want 0/0/0",
                 i, query_ready_1, query_ready_2, query_data_1);
      end
    end
    tick();
    checks++;
    if (commit_en !== 1'b0) begin
      failures++;
      $display("FAIL flush_after: cen=%b want 0", commit_en);
    end
  endtask

  task automatic test_bypass();
    logic exp_r;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_en = 1'b1;
      tick();
    end
    idle();
    wb_en = 1'b1; wb_id = 4'd2; wb_data = 32'h1234;
    query_id_1 = 4'd2;
    #1;
`ifdef ROB_WB_BYPASS_EN
    exp_r = 1'b1; exp_d = 32'h1234;
`else
    exp_r = 1'b0; exp_d = 32'h0;
`endif
    checks++;
    if (query_ready_1 !== exp_r || query_data_1 !== exp_d) begin
      failures++;
      $display("FAIL bypass_same: r=%b d=%h want %b/%h",
               query_ready_1, query_data_1, exp_r, exp_d);
    end
    tick();
    wb_en = 1'b0;
    #1;
    checks++;
    if (query_ready_1 !== 1'b1 || query_data_1 !== 32'h1234) begin
      failures++;
      $display("FAIL bypass_next: r=%b d=%h want 1/1234",
               query_ready_1, query_data_1);
    end
  endtask

  task automatic test_random();
    bit          m_valid [16];
    bit          m_done  [16];
    bit          m_we    [16];
    logic [4:0]  m_addr  [16];
    logic [31:0] m_pc    [16];
    logic [7:0]  m_exc   [16];
    logic [31:0] m_data  [16];
    int          m_head, m_count, tix;
    logic        c_en, c_we, c_exc;
    logic [4:0]  c_addr;
    logic [31:0] c_pc, c_data;
    logic [7:0]  c_type;
    logic        e_r1, e_r2;
    logic [31:0] e_d1, e_d2;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_we[i] = 0; m_addr[i] = '0;
      m_pc[i] = '0; m_exc[i] = '0; m_data[i] = '0;
    end
    m_head = 0; m_count = 0;
    c_en = 0; c_we = 0; c_exc = 0; c_addr = '0;
    c_pc = '0; c_data = '0; c_type = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      flush                = ($urandom_range(0, 39) == 0);
      alloc_en             = ($urandom_range(0, 9) < 6);
      alloc_done           = ($urandom_range(0, 9) < 3);
      alloc_reg_write_en   = 1'($urandom);
      alloc_reg_write_addr = 5'($urandom);
      alloc_exception_type = ($urandom_range(0, 9) == 0) ?
                             8'($urandom_range(1, 255)) : 8'h0;
      alloc_pc             = $urandom;
      wb_en                = ($urandom_range(0, 9) < 5);
      wb_id                = (m_count > 0 && $urandom_range(0, 3) != 0) ?
        4'((m_head + $urandom_range(0, m_count - 1)) % 16) : 4'($urandom);
      wb_data              = $urandom;
      wb_exception_type    = ($urandom_range(0, 19) == 0) ?
                             8'($urandom) : 8'h0;
      query_id_1           = ($urandom_range(0, 1) == 0) ?
                             wb_id : 4'($urandom);
      query_id_2           = 4'($urandom);
      #1;
      e_r1 = m_valid[query_id_1] && m_done[query_id_1];
      e_d1 = m_valid[query_id_1] ? m_data[query_id_1] : 32'h0;
      e_r2 = m_valid[query_id_2] && m_done[query_id_2];
      e_d2 = m_valid[query_id_2] ? m_data[query_id_2] : 32'h0;
`ifdef ROB_WB_BYPASS_EN
      if (wb_en && wb_id == query_id_1 && m_valid[query_id_1]) begin
        e_r1 = 1'b1; e_d1 = wb_data;
      end
      if (wb_en && wb_id == query_id_2 && m_valid[query_id_2]) begin
        e_r2 = 1'b1; e_d2 = wb_data;
      end
`endif
      checks++;
      if (full !== (m_count == 16) ||
          alloc_id !== 4'((m_head + m_count) % 16)) begin
        failures++;
        $display("FAIL rnd_ptr c%0d: full=%b id=%0d want %b/%0d", cyc,
                 full, alloc_id, m_count == 16, (m_head + m_count) % 16);
      end
      checks++;
      if (query_ready_1 !== e_r1 || query_data_1 !== e_d1 ||
          query_ready_2 !== e_r2 || query_data_2 !== e_d2) begin
        failures++;
        $display("FAIL rnd_query c%0d: %b/%h %b/%h want %b/%h %b/%h",
                 cyc, query_ready_1, query_data_1, query_ready_2,
                 query_data_2, e_r1, e_d1, e_r2, e_d2);
      end
      if (flush) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_head = 0; m_count = 0; c_en = 0;
      end else begin
        tix = (m_head + m_count) % 16;
        c_en = (m_count > 0) && m_done[m_head];
        if (c_en) begin
          c_exc  = (m_exc[m_head] != 0);
          c_we   = m_we[m_head] && !c_exc;
          c_addr = m_addr[m_head];
          c_pc   = m_pc[m_head];
          c_data = m_data[m_head];
          c_type = m_exc[m_head];
        end
        if (wb_en && m_valid[wb_id]) begin
          m_done[wb_id] = 1;
          m_data[wb_id] = wb_data;
          m_exc[wb_id]  = m_exc[wb_id] | wb_exception_type;
        end
        if (c_en) begin
          m_valid[m_head] = 0;
          m_head = (m_head + 1) % 16;
          m_count--;
        end
        if (alloc_en && !(m_count == 16 && !c_en) &&
            !(m_count == 15 && c_en && tix == (m_head + 15) % 16 &&
              0)) begin
          if (m_count + (c_en ? 1 : 0) < 16) begin
            m_valid[tix] = 1;
            m_done[tix]  = alloc_done || (alloc_exception_type != 0);
            m_we[tix]    = alloc_reg_write_en;
            m_addr[tix]  = alloc_reg_write_addr;
            m_pc[tix]    = alloc_pc;
            m_exc[tix]   = alloc_exception_type;
            m_data[tix]  = '0;
            m_count++;
          end
        end
      end
      tick();
      checks++;
      if (commit_en !== c_en || commit_exc !== c_exc ||
          commit_reg_write_en !== c_we ||
          commit_reg_write_addr !== c_addr || commit_pc !== c_pc ||
          commit_data !== c_data || commit_exception_type !== c_type) begin
        failures++;
        $display("FAIL rnd_commit c%0d: en=%b pc=%h d=%h x=%b t=%h we=%b a=%0d want %b/%h/%h/%b/%h/%b/%0d",
                 cyc, commit_en, commit_pc, commit_data, commit_exc,
                 commit_exception_type, commit_reg_write_en,
                 commit_reg_write_addr, c_en, c_pc, c_data, c_exc,
                 c_type, c_we, c_addr);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_alloc_commit();
    test_full_wrap();
    test_exception();
    test_flush();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
